// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point arithmetic datapaths (multiplier and divider).
package fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    localparam int TWOS_MAX_WIDTH = 64;

    // Two's-complement negation of the low 'width' bits; higher bits are cleared.
    function automatic logic [TWOS_MAX_WIDTH-1:0] twos_neg(
        input logic [TWOS_MAX_WIDTH-1:0] value,
        input int                        width
    );
        logic [TWOS_MAX_WIDTH-1:0] mask;
        mask = (width >= TWOS_MAX_WIDTH) ? '1
             : ((TWOS_MAX_WIDTH'(1) << width) - TWOS_MAX_WIDTH'(1));
        return (~value + TWOS_MAX_WIDTH'(1)) & mask;
    endfunction

endpackage

// File: rtl/seq_signed_divider_abs.sv
// Combinational sign/magnitude split of a two's-complement value.
// The magnitude is unsigned, so the most negative input maps to 2**(WIDTH-1) without an extra bit.
module twos_comp_abs #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] magnitude,
    output logic             sign
);
    import fixed_point_pkg::*;

    always_comb begin
        sign      = value[WIDTH-1];
        magnitude = sign ? WIDTH'(twos_neg(TWOS_MAX_WIDTH'(value), WIDTH)) : value;
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring radix-2 on magnitudes, one quotient bit per clock,
// sign fix-up in a final cycle. Divide-by-zero and MIN/-1 bypass the iteration.
module seq_signed_divider #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero,
    output logic                      overflow
);
    import fixed_point_pkg::*;

    localparam int DW    = DIVIDEND_WIDTH;
    localparam int SW    = DIVISOR_WIDTH;
    localparam int CNT_W = $clog2(DW + 1);
    localparam logic [DW-1:0] DVD_MIN = {1'b1, {(DW-1){1'b0}}};

    div_state_e     state;
    logic [DW-1:0]  dvd_shift;
    logic [SW:0]    part_rem;
    logic [SW-1:0]  dsr_mag;
    logic           q_neg;
    logic           r_neg;
    logic [CNT_W-1:0] iter_cnt;

    logic [DW-1:0]  dvd_mag_in;
    logic           dvd_sign;
    logic [SW-1:0]  dsr_mag_in;
    logic           dsr_sign;
    logic [SW+1:0]  shifted;
    logic [SW+1:0]  trial;
    logic           is_zero_div;
    logic           is_overflow;

    twos_comp_abs #(.WIDTH(DW)) u_dvd_abs (
        .value     (dividend),
        .magnitude (dvd_mag_in),
        .sign      (dvd_sign)
    );

    twos_comp_abs #(.WIDTH(SW)) u_dsr_abs (
        .value     (divisor),
        .magnitude (dsr_mag_in),
        .sign      (dsr_sign)
    );

    // dvd_shift feeds dividend bits out of its MSB and takes quotient bits in at its LSB.
    always_comb begin
        shifted     = {part_rem, dvd_shift[DW-1]};
        trial       = shifted - {2'b00, dsr_mag};
        is_zero_div = (divisor == '0);
        is_overflow = (dividend == DVD_MIN) && (divisor == '1);
        in_ready    = (state == IDLE);
        out_valid   = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dvd_shift   <= '0;
            part_rem    <= '0;
            dsr_mag     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            iter_cnt    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_shift <= dvd_mag_in;
                        dsr_mag   <= dsr_mag_in;
                        part_rem  <= '0;
                        q_neg     <= dvd_sign ^ dsr_sign;
                        r_neg     <= dvd_sign;
                        iter_cnt  <= CNT_W'(DW);
                        if (is_zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend[SW-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            state       <= DONE;
                        end else if (is_overflow) begin
                            quotient    <= DVD_MIN;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_shift <= {dvd_shift[DW-2:0], ~trial[SW+1]};
                    part_rem  <= trial[SW+1] ? shifted[SW:0] : trial[SW:0];
                    iter_cnt  <= iter_cnt - CNT_W'(1);
                    if (iter_cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= q_neg ? DW'(twos_neg(TWOS_MAX_WIDTH'(dvd_shift), DW)) : dvd_shift;
                    remainder <= r_neg ? SW'(twos_neg(TWOS_MAX_WIDTH'(part_rem[SW-1:0]), SW))
                                       : part_rem[SW-1:0];
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and small randomised checks for seq_signed_divider at 32/16.
module tb_seq_signed_divider;

    localparam int DW = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [SW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_signed_divider #(
        .DIVIDEND_WIDTH (DW),
        .DIVISOR_WIDTH  (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [SW-1:0] b,
                          input logic [DW-1:0] eq, input logic [SW-1:0] er,
                          input logic edbz, input logic eovf, input int elat,
                          input int ready_delay);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_q"}, 64'(quotient), 64'(eq));
        check({tag, "_r"}, 64'(remainder), 64'(er));
        check({tag, "_flags"}, 64'({div_by_zero, overflow}), 64'({edbz, eovf}));
        repeat (ready_delay) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [SW-1:0] rb;
        logic [DW-1:0] rq;
        logic [SW-1:0] rr;
        logic          rdbz;
        logic          rovf;
        int            rlat;
        int            sa;
        int            sb;

        #1;
        check("reset_async", 64'({in_ready, out_valid, div_by_zero, overflow}), 64'(4'b1000));
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", 64'(quotient), 64'(0));
        check("reset_r", 64'(remainder), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("p100_p7", 32'd100, 16'd7, 32'h0000000E, 16'h0002, 1'b0, 1'b0, 34, 0);
        run_op("m100_p7", -32'sd100, 16'd7, 32'hFFFFFFF2, 16'hFFFE, 1'b0, 1'b0, 34, 0);
        run_op("m100_m7", -32'sd100, -16'sd7, 32'h0000000E, 16'hFFFE, 1'b0, 1'b0, 34, 0);
        run_op("p100_m7", 32'd100, -16'sd7, 32'hFFFFFFF2, 16'h0002, 1'b0, 1'b0, 34, 0);
        run_op("div0_p5", 32'd5, 16'd0, 32'hFFFFFFFF, 16'h0005, 1'b1, 1'b0, 1, 0);
        run_op("div0_m100", -32'sd100, 16'd0, 32'hFFFFFFFF, 16'hFF9C, 1'b1, 1'b0, 1, 0);
        run_op("min_m1", 32'h80000000, 16'hFFFF, 32'h80000000, 16'h0000, 1'b0, 1'b1, 1, 0);
        run_op("min_min", 32'h80000000, 16'h8000, 32'h00010000, 16'h0000, 1'b0, 1'b0, 34, 0);
        run_op("min_7fff", 32'h80000000, 16'h7FFF, 32'hFFFEFFFE, 16'hFFFE, 1'b0, 1'b0, 34, 0);
        run_op("max_p1", 32'h7FFFFFFF, 16'h0001, 32'h7FFFFFFF, 16'h0000, 1'b0, 1'b0, 34, 0);
        run_op("p7_m1", 32'd7, 16'hFFFF, 32'hFFFFFFF9, 16'h0000, 1'b0, 1'b0, 34, 0);
        run_op("m1_p2", 32'hFFFFFFFF, 16'd2, 32'h00000000, 16'hFFFF, 1'b0, 1'b0, 34, 0);
        run_op("zero_p5", 32'd0, 16'd5, 32'h00000000, 16'h0000, 1'b0, 1'b0, 34, 0);

        // Backpressure: result held for 10 cycles while stray in_valid pulses are ignored.
        dividend = 32'd1000;
        divisor  = 16'd10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (33) begin
            @(posedge clk); #1;
        end
        check("bp_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = 32'd55;
            divisor  = 16'd5;
            @(posedge clk); #1;
            check("bp_hold_q", 64'(quotient), 64'(100));
            check("bp_hold_r", 64'(remainder), 64'(0));
            check("bp_hold_hs", 64'({out_valid, in_ready}), 64'(2'b10));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", 64'({out_valid, in_ready}), 64'(2'b01));

        // Reset in CALC aborts the operation.
        dividend = 32'd100;
        divisor  = 16'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_hs", 64'({out_valid, in_ready}), 64'(2'b01));
        check("abort_q", 64'(quotient), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_reset_9_3", 32'd9, 16'd3, 32'd3, 16'd0, 1'b0, 1'b0, 34, 0);

        // Randomised signed sweep against C-style truncating division.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = 16'($urandom);
            if (i % 4 == 1) ra = DW'($signed(16'($urandom)));
            if (i % 8 == 3) rb = 16'($urandom_range(0, 4)) - 16'd2;
            if (i == 5) begin ra = 32'h80000000; rb = 16'hFFFF; end
            if (rb == '0) begin
                rq = '1; rr = ra[SW-1:0]; rdbz = 1'b1; rovf = 1'b0; rlat = 1;
            end else if (ra == 32'h80000000 && rb == 16'hFFFF) begin
                rq = 32'h80000000; rr = '0; rdbz = 1'b0; rovf = 1'b1; rlat = 1;
            end else begin
                sa = $signed(ra);
                sb = $signed(rb);
                rq = sa / sb;
                rr = SW'(sa % sb);
                rdbz = 1'b0; rovf = 1'b0; rlat = 34;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_op("random", ra, rb, rq, rr, rdbz, rovf, rlat, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
